// File: rtl/seq_mult_ctrl.sv
// Sequential shift-add unsigned multiplier with start/ready/done handshake.
// Each CALC cycle adds one shifted partial product, so a WIDTH x WIDTH product
// takes WIDTH cycles plus one DONE cycle.
module seq_mult_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_reg_q, a_reg_d;
  logic [WIDTH-1:0]     b_reg_q, b_reg_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 ready_q, ready_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic [2*WIDTH-1:0]   addend;
  logic [2*WIDTH-1:0]   acc_sum;

  // Next-state, datapath and registered-output logic
  always_comb begin
    state_d   = state_q;
    a_reg_d   = a_reg_q;
    b_reg_d   = b_reg_q;
    acc_d     = acc_q;
    product_d = product_q;
    count_d   = count_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    addend  = {{WIDTH{1'b0}}, a_reg_q} << count_q;
    acc_sum = b_reg_q[count_q] ? (acc_q + addend) : acc_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_reg_d = a;
          b_reg_d = b;
          acc_d   = '0;
          count_d = '0;
          state_d = CALC;
          ready_d = 1'b0;
          busy_d  = 1'b1;
        end
      end
      CALC: begin
        acc_d   = acc_sum;
        count_d = count_q + 1'b1;
        // The final step's add goes straight into product, not via acc_q.
        if (count_q == LAST) begin
          product_d = acc_sum;
          state_d   = DONE;
          done_d    = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = IDLE;
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      a_reg_q   <= '0;
      b_reg_q   <= '0;
      acc_q     <= '0;
      product_q <= '0;
      count_q   <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_reg_q   <= a_reg_d;
      b_reg_q   <= b_reg_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      count_q   <= count_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign ready   = ready_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_mult_ctrl.sv
// Directed testbench for seq_mult_ctrl (WIDTH=4).
module tb_seq_mult_ctrl;

  localparam int W = 4;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           ready;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;

  int unsigned checks   = 0;
  int unsigned failures = 0;

  seq_mult_ctrl #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .a       (a),
    .b       (b),
    .ready   (ready),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic [2*W-1:0] exp_prod);
    check({tag, "_ready"}, 32'(ready), 32'd1);
    check({tag, "_busy"},  32'(busy),  32'd0);
    check({tag, "_done"},  32'(done),  32'd0);
    check({tag, "_prod"},  32'(product), 32'(exp_prod));
  endtask

  // One full operation: pulse start, measure latency, check result and return to idle.
  task automatic do_mult(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb_,
                         input logic [2*W-1:0] exp);
    int unsigned n;
    logic [2*W-1:0] model;
    model = 8'(ta) * 8'(tb_);
    a = ta;
    b = tb_;
    start = 1'b1;
    step();
    start = 1'b0;
    a = ~ta;
    b = ~tb_;
    check({tag, "_busy_after_accept"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 20) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, 32'd4);
    check({tag, "_prod"},  32'(product), 32'(exp));
    check({tag, "_model"}, 32'(product), 32'(model));
    check({tag, "_busy_in_done"}, 32'(busy), 32'd1);
    step();
    check_idle({tag, "_after"}, exp);
  endtask

  initial begin
    int unsigned ndone;
    int unsigned t_first;
    int unsigned t_second;
    logic [2*W-1:0] seen;

    rst_n = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    step();
    step();
    rst_n = 1'b1;
    #1;
    check_idle("reset", 8'h00);
    for (int i = 0; i < 3; i++) step();
    check_idle("idle_hold", 8'h00);

    do_mult("basic_10x5", 4'd10, 4'd5, 8'h32);
    do_mult("c_15x15",    4'd15, 4'd15, 8'hE1);
    do_mult("c_0x9",      4'd0,  4'd9,  8'h00);
    do_mult("c_9x0",      4'd9,  4'd0,  8'h00);
    do_mult("c_1x15",     4'd1,  4'd15, 8'h0F);

    // Start while busy: second request must be ignored.
    a = 4'd3; b = 4'd4; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    a = 4'd7; b = 4'd7; start = 1'b1;
    step();
    start = 1'b0;
    ndone = 0;
    seen  = '0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        ndone++;
        seen = product;
      end
      step();
    end
    check("busy_start_ndone", ndone, 32'd1);
    check("busy_start_prod", 32'(seen), 32'h0C);
    check_idle("busy_start_after", 8'h0C);

    // Back-to-back with start held high.
    a = 4'd2; b = 4'd3; start = 1'b1;
    step();
    a = 4'd6; b = 4'd7;
    ndone = 0; t_first = 0; t_second = 0;
    for (int unsigned i = 1; i <= 30 && ndone < 2; i++) begin
      step();
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          t_first = i;
          check("b2b_first_prod", 32'(product), 32'h06);
        end else begin
          t_second = i;
          start = 1'b0;
          check("b2b_second_prod", 32'(product), 32'h2A);
        end
      end else if (ndone == 1) begin
        check("b2b_hold", 32'(product), 32'h06);
      end
    end
    start = 1'b0;
    check("b2b_ndone", ndone, 32'd2);
    check("b2b_first_lat", t_first, 32'd4);
    check("b2b_spacing", t_second - t_first, 32'd6);
    step();
    step();
    check_idle("b2b_after", 8'h2A);

    // Reset in the middle of a calculation.
    a = 4'd15; b = 4'd15; start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    check("rst_mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    check_idle("rst_mid_async", 8'h00);
    step();
    rst_n = 1'b1;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (done) ndone++;
    end
    check("rst_mid_no_done", ndone, 32'd0);
    check_idle("rst_mid_idle", 8'h00);
    do_mult("post_rst_4x4", 4'd4, 4'd4, 8'h10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
